trace_logger: RTL and testbench

- Next-generation trace/stream logger between the Tracer and the trace memory.
- Fully parametrised in data width, depth and trigger-delay resolution.
- Uses a true dual-port memory, so there is no RW turn strobe: one write and one read can happen in the same cycle.
- Adds features the current logger lacks: an explicit arm/re-arm state machine, circular overwrite of pre-trigger history, streaming back-pressure with a saturating drop counter, and a fill-level output.

---
 rtl/trace_logger.sv | 208 ++++++++++++++++++++
 tb/tb_trace_logger.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_logger.sv
// ---------------------------------------------------------------------------
// trace_logger
//
// Trace/stream logger sitting between the Tracer and a true dual-port trace
// memory (one write port, one 1-cycle synchronous read port).
//
// Trace mode (MODE_I=0 at arm):
//   - RUN keeps circular pre-trigger history; storing when full overwrites
//     the oldest word.
//   - A trigger moves to POST.
//   - POST accepts L+1 more words, L = ((delay+1)*(DEPTH-1)) >> DELAY_BITS.
//   - DONE freezes the buffer and allows it to be read out.
// Streaming mode (MODE_I=1 at arm):
//   - RUN behaves as a FIFO with back-pressure.
//   - Stores refused while full are counted in a saturating drop counter.
//
// Ports
//   CLK_I, RST_NI        clock, asynchronous active-low reset
//   ARM_I                (re)start capture; latches MODE_I and TRG_DELAY_I
//   MODE_I               0 = trace, 1 = streaming
//   TRG_DELAY_I          post-trigger ratio
//   TRG_EVENT_I          trigger from the Tracer (trace mode, RUN only)
//   STORE_I / DATA_I     store request and word
//   STORE_PERM_O         a store this cycle would be accepted
//   LOAD_REQUEST_I       request the next stored word
//   LOAD_GRANT_O/DATA_O  one-cycle pulse with the word read
//   MEM_*                memory write port / read address / read data
//   FILL_O               stored, unread entries
//   EVENT_ADDR_O         address of the first post-trigger entry
//   TRG_DELAYED_O        post-trigger window complete
//   DROP_CNT_O           stores rejected in streaming mode
//   STATE_O              IDLE=0, RUN=1, POST=2, DONE=3
// ---------------------------------------------------------------------------
module trace_logger #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 6,
  parameter int DELAY_BITS = 3,
  parameter int DROP_W     = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  ARM_I,
  input  logic                  MODE_I,
  input  logic [DELAY_BITS-1:0] TRG_DELAY_I,
  input  logic                  TRG_EVENT_I,
  input  logic                  STORE_I,
  input  logic [DATA_W-1:0]     DATA_I,
  output logic                  STORE_PERM_O,
  input  logic                  LOAD_REQUEST_I,
  output logic                  LOAD_GRANT_O,
  output logic [DATA_W-1:0]     DATA_O,
  output logic                  MEM_WE_O,
  output logic [ADDR_W-1:0]     MEM_WADDR_O,
  output logic [DATA_W-1:0]     MEM_WDATA_O,
  output logic [ADDR_W-1:0]     MEM_RADDR_O,
  input  logic [DATA_W-1:0]     MEM_RDATA_I,
  output logic [ADDR_W:0]       FILL_O,
  output logic [ADDR_W-1:0]     EVENT_ADDR_O,
  output logic                  TRG_DELAYED_O,
  output logic [DROP_W-1:0]     DROP_CNT_O,
  output logic [1:0]            STATE_O
);

  localparam int PTR_W   = ADDR_W + 1;
  localparam int DEPTH_I = 1 << ADDR_W;
  localparam int PROD_W  = DELAY_BITS + 1 + ADDR_W;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(DEPTH_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic                    r_mode;
  logic [DELAY_BITS-1:0]   r_delay;
  logic [ADDR_W-1:0]       r_hist;
  logic [ADDR_W-1:0]       r_event_addr;
  logic [DROP_W-1:0]       r_drop_cnt;
  logic                    r_rd_busy;
  logic                    r_grant;
  logic [DATA_W-1:0]       r_data;

  logic [PTR_W-1:0]        w_fill;
  logic                    w_full, w_empty;
  logic                    w_perm, w_rd_allow;
  logic                    w_we, w_rd_fire, w_trigger, w_post_last;
  logic                    w_overwrite, w_drop;
  logic [PROD_W-1:0]       w_hist_prod;
  logic [ADDR_W-1:0]       w_hist_load;

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == DEPTH);
  assign w_empty = (w_fill == '0);

  // Post-trigger length; the product never overflows PROD_W bits.
  assign w_hist_prod = (PROD_W'(r_delay) + PROD_W'(1)) * PROD_W'(DEPTH_I - 1);
  assign w_hist_load = ADDR_W'(w_hist_prod >> DELAY_BITS);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (ARM_I) begin
      w_state_nxt = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:   if (w_trigger)   w_state_nxt = S_POST;
        S_POST:  if (w_post_last) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // ---------------- FSM: outputs / permissions ----------------
  always_comb begin
    w_perm     = 1'b0;
    w_rd_allow = 1'b0;
    if (r_mode) begin
      // Back-pressure looks at the current fill only; a same-cycle read
      // does not free space.
      w_perm     = (r_state == S_RUN) && !w_full;
      w_rd_allow = (r_state == S_RUN);
    end else begin
      w_perm     = (r_state == S_RUN) || (r_state == S_POST);
      w_rd_allow = (r_state == S_DONE);
    end
  end

  assign w_we        = STORE_I & w_perm;
  assign w_rd_fire   = LOAD_REQUEST_I & !w_empty & w_rd_allow & !r_rd_busy & !ARM_I;
  assign w_trigger   = !r_mode && (r_state == S_RUN) && TRG_EVENT_I;
  assign w_post_last = (r_state == S_POST) && w_we && (r_hist == '0);
  // Trace history is circular: a store into a full buffer drops the oldest.
  assign w_overwrite = !r_mode && w_we && w_full;
  assign w_drop      = r_mode && (r_state == S_RUN) && STORE_I && w_full;

  // ---------------- Pointers, trigger bookkeeping, drop counter ----------------
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mode       <= 1'b0;
      r_delay      <= '0;
      r_hist       <= '0;
      r_event_addr <= '0;
      r_drop_cnt   <= '0;
    end else if (ARM_I) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mode       <= MODE_I;
      r_delay      <= TRG_DELAY_I;
      r_hist       <= '0;
      r_event_addr <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_we)                     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_fire || w_overwrite) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      if (w_trigger) begin
        // A store in the trigger cycle is pre-trigger history.
        r_event_addr <= r_wr_ptr[ADDR_W-1:0] + ADDR_W'(w_we);
        r_hist       <= w_hist_load;
      end else if ((r_state == S_POST) && w_we && (r_hist != '0)) begin
        r_hist <= r_hist - ADDR_W'(1);
      end
    end
  end

  // ---------------- Read pipeline (1-cycle synchronous memory) ----------------
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_rd_busy <= 1'b0;
      r_grant   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_busy <= w_rd_fire;
      r_grant   <= r_rd_busy;
      if (r_rd_busy) r_data <= MEM_RDATA_I;
    end
  end

  assign STORE_PERM_O  = w_perm;
  assign MEM_WE_O      = w_we;
  assign MEM_WADDR_O   = r_wr_ptr[ADDR_W-1:0];
  assign MEM_WDATA_O   = DATA_I;
  assign MEM_RADDR_O   = r_rd_ptr[ADDR_W-1:0];
  assign LOAD_GRANT_O  = r_grant;
  assign DATA_O        = r_data;
  assign FILL_O        = w_fill;
  assign EVENT_ADDR_O  = r_event_addr;
  assign TRG_DELAYED_O = (r_state == S_DONE);
  assign DROP_CNT_O    = r_drop_cnt;
  assign STATE_O       = r_state;

endmodule

// File: tb/tb_trace_logger.sv
// ---------------------------------------------------------------------------
// tb_trace_logger: directed self-checking bench for trace_logger with
// DEPTH=16, DELAY_BITS=3 and a behavioural 1-cycle synchronous dual-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_trace_logger;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int DELAY_BITS = 3;
  localparam int DROP_W     = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  arm = 1'b0, mode = 1'b0, trg = 1'b0, store = 1'b0, req = 1'b0;
  logic [DELAY_BITS-1:0] delay = '0;
  logic [DATA_W-1:0]     din = '0;
  logic                  perm, grant, mem_we, trg_delayed;
  logic [DATA_W-1:0]     dout, mem_wdata;
  logic [DATA_W-1:0]     mem_rdata = '0;
  logic [ADDR_W-1:0]     mem_waddr, mem_raddr, event_addr;
  logic [ADDR_W:0]       fill;
  logic [DROP_W-1:0]     drop_cnt;
  logic [1:0]            state;

  logic [DATA_W-1:0]     mem [16];

  int total = 0;
  int bad   = 0;

  trace_logger #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DELAY_BITS(DELAY_BITS), .DROP_W(DROP_W)
  ) dut (
    .CLK_I(clk), .RST_NI(rst_n), .ARM_I(arm), .MODE_I(mode),
    .TRG_DELAY_I(delay), .TRG_EVENT_I(trg), .STORE_I(store), .DATA_I(din),
    .STORE_PERM_O(perm), .LOAD_REQUEST_I(req), .LOAD_GRANT_O(grant),
    .DATA_O(dout), .MEM_WE_O(mem_we), .MEM_WADDR_O(mem_waddr),
    .MEM_WDATA_O(mem_wdata), .MEM_RADDR_O(mem_raddr), .MEM_RDATA_I(mem_rdata),
    .FILL_O(fill), .EVENT_ADDR_O(event_addr), .TRG_DELAYED_O(trg_delayed),
    .DROP_CNT_O(drop_cnt), .STATE_O(state)
  );

  always #5 clk = ~clk;

  // Behavioural memory: write port plus registered read (old data on collision).
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic [DELAY_BITS-1:0] d);
    arm = 1'b1; mode = m; delay = d;
    tick();
    arm = 1'b0; mode = ~m; delay = ~d;   // later changes must have no effect
  endtask

  task automatic store_word(input logic [DATA_W-1:0] v);
    store = 1'b1; din = v;
    tick();
    store = 1'b0;
  endtask

  // Request at edge k: no grant after k, grant with data after k+1.
  task automatic do_read(input string tag, input logic [DATA_W-1:0] exp);
    req = 1'b1;
    tick();
    req = 1'b0;
    check({tag, "_nogrant"}, grant, 1'b0);
    tick();
    check({tag, "_grant"}, grant, 1'b1);
    check({tag, "_data"}, dout, exp);
  endtask

  logic [DATA_W-1:0] exp_rd [16];

  initial begin
    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", state, 2'd0);
    check("rst_fill", fill, 0);
    check("rst_perm", perm, 1'b0);
    check("rst_grant", grant, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- trace, delay 3 ----------------
    do_arm(1'b0, 3'd3);
    check("t1_state_run", state, 2'd1);
    for (int i = 0; i < 20; i++) store_word(DATA_W'(i));
    check("t1_fill_full", fill, 16);
    trg = 1'b1;
    tick();
    trg = 1'b0;
    check("t1_state_post", state, 2'd2);
    check("t1_event_addr", event_addr, 4);
    for (int i = 0; i < 16; i++) begin
      store = 1'b1; din = DATA_W'(100 + i);
      #0;
      check("t1_perm", perm, (i < 8));
      check("t1_mem_we", mem_we, (i < 8));
      tick();
      check("t1_state", state, (i >= 7) ? 2'd3 : 2'd2);
    end
    store = 1'b0;
    check("t1_trg_delayed", trg_delayed, 1'b1);
    check("t1_fill_done", fill, 16);
    for (int i = 0; i < 4; i++)  exp_rd[i] = DATA_W'(12 + i);
    for (int i = 0; i < 4; i++)  exp_rd[4 + i] = DATA_W'(16 + i);
    for (int i = 0; i < 8; i++)  exp_rd[8 + i] = DATA_W'(100 + i);
    for (int i = 0; i < 16; i++) do_read("t1_rd", exp_rd[i]);
    check("t1_fill_empty", fill, 0);
    req = 1'b1;
    tick(); check("t1_empty_nogrant_a", grant, 1'b0);
    tick(); check("t1_empty_nogrant_b", grant, 1'b0);
    req = 1'b0;

    // ---------------- trace, delay 7 then delay 0 ----------------
    do_arm(1'b0, 3'd7);
    for (int i = 0; i < 3; i++) store_word(DATA_W'(i));
    trg = 1'b1; tick(); trg = 1'b0;
    for (int i = 0; i < 16; i++) begin
      store_word(DATA_W'(200 + i));
      check("t2_d7_delayed", trg_delayed, (i == 15));
    end
    check("t2_d7_state", state, 2'd3);

    do_arm(1'b0, 3'd0);
    check("t2_rearm_delayed", trg_delayed, 1'b0);
    for (int i = 0; i < 3; i++) store_word(DATA_W'(i));
    trg = 1'b1; tick(); trg = 1'b0;
    for (int i = 0; i < 2; i++) begin
      store_word(DATA_W'(300 + i));
      check("t2_d0_delayed", trg_delayed, (i == 1));
    end
    check("t2_d0_fill", fill, 5);

    // ---------------- streaming ----------------
    do_arm(1'b1, 3'd0);
    for (int i = 0; i < 19; i++) begin
      store = 1'b1; din = DATA_W'(i);
      #0;
      check("t3_perm", perm, (i < 16));
      tick();
    end
    store = 1'b0;
    check("t3_fill", fill, 16);
    check("t3_drop", drop_cnt, 3);
    check("t3_perm_full", perm, 1'b0);
    trg = 1'b1; tick(); trg = 1'b0;
    check("t3_trg_ignored", state, 2'd1);
    do_read("t3_rd0", 0);
    check("t3_perm_after_rd", perm, 1'b1);
    // Held request: grants every second cycle.
    req = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick();
      check("t3_hold_grant", grant, j[0]);
      if (j[0]) check("t3_hold_data", dout, DATA_W'(1 + j / 2));
    end
    tick(); check("t3_empty_nogrant_a", grant, 1'b0);
    tick(); check("t3_empty_nogrant_b", grant, 1'b0);
    req = 1'b0;
    check("t3_fill_empty", fill, 0);

    // ---------------- wrap and concurrency ----------------
    do_arm(1'b1, 3'd0);
    for (int i = 0; i < 15; i++) store_word(DATA_W'(i));
    check("t4_fill_start", fill, 15);
    for (int i = 0; i < 40; i++) begin
      store = 1'b1; din = DATA_W'(15 + i); req = 1'b1;
      tick();
      store = 1'b0; req = 1'b0;
      check("t4_fill_a", fill, 15);
      tick();
      check("t4_grant", grant, 1'b1);
      check("t4_data", dout, DATA_W'(i));
    end
    check("t4_drop", drop_cnt, 0);

    // ---------------- reset mid-POST ----------------
    do_arm(1'b0, 3'd7);
    for (int i = 0; i < 5; i++) store_word(DATA_W'(i));
    trg = 1'b1; tick(); trg = 1'b0;
    store_word(16'h00aa);
    store_word(16'h00bb);
    check("t5_pre_state", state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_state", state, 2'd0);
    check("t5_rst_fill", fill, 0);
    check("t5_rst_event", event_addr, 0);
    check("t5_rst_data", dout, 0);
    check("t5_rst_delayed", trg_delayed, 1'b0);
    check("t5_rst_drop", drop_cnt, 0);
    check("t5_rst_perm", perm, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- re-arm from DONE ----------------
    do_arm(1'b0, 3'd0);
    for (int i = 0; i < 4; i++) store_word(DATA_W'(i));
    trg = 1'b1; tick(); trg = 1'b0;
    store_word(16'h0050);
    store_word(16'h0051);
    check("t6_done", state, 2'd3);
    check("t6_fill", fill, 6);
    check("t6_event", event_addr, 4);
    do_arm(1'b0, 3'd0);
    check("t6_rearm_state", state, 2'd1);
    check("t6_rearm_fill", fill, 0);
    check("t6_rearm_event", event_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
